// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: state encoding, output buffer depth and ring-pointer helper for fifo_stream_reader
package fifo_reader_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_e;
    localparam int OBUF_DEPTH = 3;
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_stream_reader_obuf.sv
// stream_obuf: 3-entry ring buffer that holds FIFO words until the stream accepts them
// ports: clk, srstn (async active-low), push/push_data (write), pop (read head),
//        head_data (oldest word), count (occupancy 0..3)
module stream_obuf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);
    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [OBUF_DEPTH];
    logic [1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        do_pop  = pop && cnt_q != 2'd0;
        // a push into a full buffer is only legal when a pop frees a slot in the same cycle
        do_push = push && (cnt_q != 2'(OBUF_DEPTH) || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign head_data = mem_q[rd_q];
    assign count     = cnt_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: reads a burst of words from a FIFO and presents them as a valid/ready stream
// ports: clk, srstn (async active-low); start/burst_len request a burst;
//        fifo_dout/fifo_empty/fifo_rd_en talk to the FIFO (data one cycle after rd_en);
//        m_data/m_valid/m_ready/m_last form the stream; busy = not idle, done = burst complete pulse
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_ADDR  = 4,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    if (DATA_ADDR < 1) begin : g_bad_addr
        $error("DATA_ADDR must be at least 1");
    end
    state_e state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, issued_q, issued_d, accepted_q, accepted_d;
    logic inflight_q, inflight_d;
    logic [1:0] ob_count;
    logic [DATA_WIDTH-1:0] ob_head;
    logic room, last_word, hs;
    always_comb begin
        // read credit counts words already buffered plus the read whose data lands next cycle,
        // so rd_en never depends on m_ready
        room       = ({1'b0, ob_count} + {2'b00, inflight_q}) < 3'(OBUF_DEPTH);
        fifo_rd_en = state_q == ST_RUN && !fifo_empty && issued_q < len_q && room;
        inflight_d = fifo_rd_en;
        m_valid    = ob_count != 2'd0;
        last_word  = accepted_q == len_q - 1'b1;
        m_last     = m_valid && last_word;
        m_data     = m_valid ? ob_head : '0;
        hs         = m_valid && m_ready;
        busy       = state_q != ST_IDLE;
        done       = state_q == ST_TAIL && hs && last_word;
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q + LEN_W'(fifo_rd_en);
        accepted_d = accepted_q + LEN_W'(hs);
        if (state_q == ST_IDLE && start && burst_len != '0) begin
            state_d    = ST_RUN;
            len_d      = burst_len;
            issued_d   = '0;
            accepted_d = '0;
        end else if (state_q == ST_RUN && issued_d == len_q) begin
            state_d = ST_TAIL;
        end else if (done) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
        end
    end
    stream_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
        .clk       (clk),
        .srstn     (srstn),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (hs),
        .head_data (ob_head),
        .count     (ob_count)
    );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench for fifo_stream_reader with a behavioural FIFO
module tb_fifo_stream_reader;
    logic clk = 1'b0, srstn = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [7:0] burst_len = 8'd0, fifo_dout = 8'd0, m_data;
    logic fifo_empty, fifo_rd_en, m_valid, m_last, busy, done;
    logic [7:0] mem [1024];
    logic [9:0] wr_ptr = 10'd0, rd_ptr = 10'd0;
    typedef struct packed {logic [7:0] data; logic last;} beat_t;
    beat_t exp_q[$];
    int checks = 0, failures = 0, reads = 0, acc = 0, done_cnt = 0, max_out = 0;
    logic hold_pend = 1'b0, hold_last = 1'b0, hs_now = 1'b0;
    logic [7:0] hold_data = 8'd0;

    fifo_stream_reader dut (
        .clk(clk), .srstn(srstn), .start(start), .burst_len(burst_len),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign fifo_empty = rd_ptr == wr_ptr;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 10'd1;
        end
    end

    task automatic put(input logic [7:0] d, input bit want, input logic last);
        beat_t e;
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 10'd1;
        e.data = d;
        e.last = last;
        if (want) exp_q.push_back(e);
    endtask

    task automatic clear_stats();
        reads = 0; acc = 0; done_cnt = 0; max_out = 0;
    endtask

    // one clock: drive inputs at negedge, sample outputs 1 time unit later, score any handshake
    task automatic step(input logic rdy, input logic st, input logic [7:0] len);
        beat_t e;
        @(negedge clk);
        m_ready = rdy; start = st; burst_len = len;
        #1;
        hs_now = m_valid && m_ready;
        if (hold_pend) begin
            checks++;
            if (!m_valid || m_data !== hold_data || m_last !== hold_last) begin
                failures++;
                $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         m_valid, m_data, m_last, hold_data, hold_last);
            end
        end
        if (fifo_rd_en) reads++;
        if (hs_now) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_extra: data=%h last=%b, required no beat", m_data, m_last);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_last !== e.last) begin
                    failures++;
                    $display("FAIL beat: data=%h last=%b, required data=%h last=%b", m_data, m_last, e.data, e.last);
                end
            end
            acc++;
        end
        if (done) begin
            done_cnt++;
            checks++;
            if (!(hs_now && m_last)) begin
                failures++;
                $display("FAIL done_align: hs=%b last=%b, required hs=1 last=1", hs_now, m_last);
            end
        end
        if (reads - acc > max_out) max_out = reads - acc;
        hold_pend = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
    endtask

    task automatic run_to_done(input string name, input int budget, input bit rnd);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 8'd0);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout: no done in %0d cycles, required done", name, budget);
        end
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        #3;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: rd_en/valid/last/busy/done=%b, required 00000",
                     {fifo_rd_en, m_valid, m_last, busy, done});
        end
        checks++;
        if (m_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: m_data=%h, required 00", m_data);
        end
        @(negedge clk);
        @(negedge clk);
        srstn = 1'b1;
    endtask

    task automatic test_basic();
        int first = -1, lastc = -1, n = 0;
        clear_stats();
        for (int i = 0; i < 4; i++) put(8'h11 + 8'(i), 1'b1, i == 3);
        step(1'b1, 1'b1, 8'd4);
        while (done_cnt == 0 && n < 30) begin
            step(1'b1, 1'b0, 8'd0);
            n++;
            if (hs_now) begin
                if (first < 0) first = n;
                lastc = n;
            end
        end
        repeat (3) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (lastc - first != 3 || acc != 4) begin
            failures++;
            $display("FAIL basic_throughput: beats=%0d span=%0d, required beats=4 span=3", acc, lastc - first);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done_cnt=%0d busy=%b, required 1 and 0", done_cnt, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_left: %0d beats missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        clear_stats();
        for (int i = 0; i < 6; i++) put(8'h21 + 8'(i), 1'b1, i == 5);
        step(1'b0, 1'b1, 8'd6);
        repeat (5) step(1'b0, 1'b0, 8'd0);
        checks++;
        if (reads != 3 || m_valid !== 1'b1 || m_data !== 8'h21) begin
            failures++;
            $display("FAIL bp_stall: reads=%0d valid=%b data=%h, required 3 1 21", reads, m_valid, m_data);
        end
        run_to_done("bp", 40, 1'b0);
        checks++;
        if (max_out > 3 || acc != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_total: max_out=%0d beats=%0d, required <=3 and 6", max_out, acc);
        end
    endtask

    task automatic test_stall();
        clear_stats();
        put(8'h31, 1'b1, 1'b0);
        put(8'h32, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd5);
        repeat (10) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (busy !== 1'b1 || acc != 2 || reads != 2 || done_cnt != 0) begin
            failures++;
            $display("FAIL stall_wait: busy=%b beats=%0d reads=%0d done=%0d, required 1 2 2 0",
                     busy, acc, reads, done_cnt);
        end
        for (int i = 0; i < 3; i++) put(8'h33 + 8'(i), 1'b1, i == 2);
        run_to_done("stall", 40, 1'b0);
        checks++;
        if (acc != 5 || exp_q.size() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_total: beats=%0d done=%0d, required 5 and 1", acc, done_cnt);
        end
    endtask

    task automatic test_ignored();
        clear_stats();
        put(8'h41, 1'b1, 1'b0);
        put(8'h42, 1'b1, 1'b1);
        put(8'h43, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd0);
        repeat (5) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (reads != 0 || busy !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL ign_len0: reads=%0d busy=%b done=%0d, required 0 0 0", reads, busy, done_cnt);
        end
        step(1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd3);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        checks++;
        if (busy !== 1'b1 || reads != 2) begin
            failures++;
            $display("FAIL ign_busy: busy=%b reads=%0d, required 1 and 2", busy, reads);
        end
        run_to_done("ign", 20, 1'b0);
        repeat (4) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (done_cnt != 1 || reads != 2 || busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ign_total: done=%0d reads=%0d busy=%b, required 1 2 0", done_cnt, reads, busy);
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_stats();
        for (int i = 0; i < 8; i++) put(8'h51 + 8'(i), 1'b1, i == 7);
        step(1'b1, 1'b1, 8'd8);
        while (acc < 2 && n < 20) begin
            step(1'b1, 1'b0, 8'd0);
            n++;
        end
        step(1'b0, 1'b0, 8'd0);
        #2 srstn = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== 8'h00 || acc != 2) begin
            failures++;
            $display("FAIL rst_mid: rd_en/valid/last/busy/done=%b data=%h beats=%0d, required 00000 00 2",
                     {fifo_rd_en, m_valid, m_last, busy, done}, m_data, acc);
        end
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        clear_stats();
        repeat (4) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (reads != 0 || acc != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_resume: reads=%0d beats=%0d busy=%b, required 0 0 0", reads, acc, busy);
        end
        wr_ptr = rd_ptr;
        put(8'h5a, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'd1);
        run_to_done("rst_new", 20, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (done_cnt != 1 || reads != 1 || acc != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_new: done=%0d reads=%0d beats=%0d, required 1 1 1", done_cnt, reads, acc);
        end
    endtask

    task automatic test_long();
        clear_stats();
        for (int i = 0; i < 255; i++) put(8'(i * 37 + 5), 1'b1, i == 254);
        step($urandom_range(0, 3) != 0, 1'b1, 8'd255);
        run_to_done("long", 2000, 1'b1);
        repeat (4) step(1'b1, 1'b0, 8'd0);
        checks++;
        if (acc != 255 || done_cnt != 1 || exp_q.size() != 0 || max_out > 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL long_total: beats=%0d done=%0d max_out=%0d busy=%b, required 255 1 <=3 0",
                     acc, done_cnt, max_out, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
